// File: rtl/sqw_pkg.sv
// Shared definitions for the square-wave generator and its sequencer.
package sqw_pkg;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } sqw_state_t;

    // clk cycles per unit of m/n (100 ns at 100 MHz); shared with the generator.
    localparam int SQW_BASE_TICKS = 10;

endpackage

// File: rtl/sqw_seq_table.sv
// Sequencer entry table: DEPTH x W register file, one write port,
// one asynchronous read port. Contents clear to zero on reset.
module sqw_seq_table
    import sqw_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem_reg [DEPTH];

    // Entry storage: cleared on reset, written when the top accepts a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/sqw_sequencer.sv
// Square-wave sequencer: plays a table of (m, n, repeat) entries into one
// generator, counting complete periods from the generator's own out signal.
// Optional feature macro: SQW_SEQ_LOOP_EN (honour loop_en; otherwise the
// sequence always ends after entry len-1 and loop_en is ignored).
module sqw_sequencer
    import sqw_pkg::*;
#(
    parameter int M     = 4,
    parameter int N     = 4,
    parameter int DEPTH = 8,
    parameter int REP_W = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [M-1:0]     wr_m,
    input  logic [N-1:0]     wr_n,
    input  logic [REP_W-1:0] wr_rep,
    output logic             wr_err,
    input  logic [AW:0]      len,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic             gen_out,
    output logic             gen_rst,
    output logic [M-1:0]     m_out,
    output logic [N-1:0]     n_out,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    cur_idx
);

    localparam int W = M + N + REP_W;

    sqw_state_t       state_reg, state_next;
    logic [M-1:0]     m_reg, m_next;
    logic [N-1:0]     n_reg, n_next;
    logic [REP_W-1:0] rep_reg, rep_next;
    logic [REP_W-1:0] per_cnt_reg, per_cnt_next;
    logic             first_reg, first_next;
    logic [AW-1:0]    idx_reg, idx_next;
    logic [AW:0]      len_reg, len_next;
    logic             done_reg, done_next;
    logic             gen_rst_reg, gen_rst_next;
    logic             wr_err_reg, wr_err_next;
    logic             gen_out_q;

    logic             wr_ok;
    logic             rise;
    logic             loop_ok;
    logic             last_entry;
    logic             period_done;
    logic             seq_end;
    logic [AW:0]      len_start;
    logic [REP_W-1:0] rep_eff;
    logic [AW-1:0]    rd_idx;
    logic [W-1:0]     rd_data;
    logic [M-1:0]     rd_m;
    logic [N-1:0]     rd_n;
    logic [REP_W-1:0] rd_rep;

`ifdef SQW_SEQ_LOOP_EN
    assign loop_ok = loop_en;
`else
    logic unused_loop_en;
    assign unused_loop_en = loop_en;
    assign loop_ok        = 1'b0;
`endif

    // The table is only modified while idle, and never with a zero high/low time.
    assign wr_ok = wr_en && (state_reg == ST_IDLE) && (wr_m != '0) && (wr_n != '0);

    sqw_seq_table #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr),
        .wr_data ({wr_rep, wr_n, wr_m}),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

    assign rd_m   = rd_data[M-1:0];
    assign rd_n   = rd_data[M+N-1:M];
    assign rd_rep = rd_data[W-1:M+N];

    // A len beyond the table would never reach its last entry; clamp it.
    assign len_start   = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
    assign last_entry  = ({1'b0, idx_reg} == (len_reg - 1'b1));
    assign rep_eff     = (rep_reg == '0) ? REP_W'(1) : rep_reg;
    assign period_done = (({1'b0, per_cnt_reg} + 1'b1) == {1'b0, rep_eff});
    // Idle reads entry 0 for the start load; running reads the entry that follows.
    assign rd_idx      = (state_reg == ST_IDLE || last_entry) ? '0 : idx_reg + 1'b1;
    assign rise        = gen_out & ~gen_out_q;

    // Previous generator output, held low while the generator is in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_out_q <= 1'b0;
        end else if (gen_rst_reg) begin
            gen_out_q <= 1'b0;
        end else begin
            gen_out_q <= gen_out;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            m_reg       <= '0;
            n_reg       <= '0;
            rep_reg     <= '0;
            per_cnt_reg <= '0;
            first_reg   <= 1'b0;
            idx_reg     <= '0;
            len_reg     <= '0;
            done_reg    <= 1'b0;
            gen_rst_reg <= 1'b1;
            wr_err_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            m_reg       <= m_next;
            n_reg       <= n_next;
            rep_reg     <= rep_next;
            per_cnt_reg <= per_cnt_next;
            first_reg   <= first_next;
            idx_reg     <= idx_next;
            len_reg     <= len_next;
            done_reg    <= done_next;
            gen_rst_reg <= gen_rst_next;
            wr_err_reg  <= wr_err_next;
        end
    end

    // Next-state logic: start/load, period counting, entry advance, stop.
    always_comb begin
        state_next   = state_reg;
        m_next       = m_reg;
        n_next       = n_reg;
        rep_next     = rep_reg;
        per_cnt_next = per_cnt_reg;
        first_next   = first_reg;
        idx_next     = idx_reg;
        len_next     = len_reg;
        done_next    = 1'b0;
        wr_err_next  = wr_en & ~wr_ok;
        seq_end      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start && (len != '0)) begin
                    state_next   = ST_RUN;
                    m_next       = rd_m;
                    n_next       = rd_n;
                    rep_next     = rd_rep;
                    per_cnt_next = '0;
                    first_next   = 1'b0;
                    idx_next     = '0;
                    len_next     = len_start;
                end
            end
            ST_RUN: begin
                if (rise) begin
                    // The first rise only marks the start of the first period.
                    if (!first_reg) begin
                        first_next = 1'b1;
                    end else if (period_done) begin
                        per_cnt_next = '0;
                        if (last_entry && !loop_ok) begin
                            seq_end    = 1'b1;
                            state_next = ST_IDLE;
                            done_next  = 1'b1;
                        end else begin
                            m_next   = rd_m;
                            n_next   = rd_n;
                            rep_next = rd_rep;
                            idx_next = rd_idx;
                        end
                    end else begin
                        per_cnt_next = per_cnt_reg + 1'b1;
                    end
                end
                // A natural end in the same cycle takes priority over stop.
                if (stop && !seq_end) begin
                    state_next = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                if (rise) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        gen_rst_next = (state_next == ST_IDLE);
    end

    assign gen_rst = gen_rst_reg;
    assign m_out   = m_reg;
    assign n_out   = n_reg;
    assign busy    = (state_reg != ST_IDLE);
    assign done    = done_reg;
    assign cur_idx = idx_reg;
    assign wr_err  = wr_err_reg;

endmodule

// File: tb/tb_sqw_sequencer.sv
// Testbench for sqw_sequencer with a behavioural square-wave generator model.
module tb_sqw_sequencer;

    localparam int M     = 4;
    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int REP_W = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [M-1:0]     wr_m = '0;
    logic [N-1:0]     wr_n = '0;
    logic [REP_W-1:0] wr_rep = '0;
    logic             wr_err;
    logic [AW:0]      len = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             loop_en = 1'b0;
    logic             gen_out;
    logic             gen_rst;
    logic [M-1:0]     m_out;
    logic [N-1:0]     n_out;
    logic             busy;
    logic             done;
    logic [AW-1:0]    cur_idx;

    sqw_sequencer #(.M(M), .N(N), .DEPTH(DEPTH), .REP_W(REP_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_m    (wr_m),
        .wr_n    (wr_n),
        .wr_rep  (wr_rep),
        .wr_err  (wr_err),
        .len     (len),
        .start   (start),
        .stop    (stop),
        .loop_en (loop_en),
        .gen_out (gen_out),
        .gen_rst (gen_rst),
        .m_out   (m_out),
        .n_out   (n_out),
        .busy    (busy),
        .done    (done),
        .cur_idx (cur_idx)
    );

    always #5 clk = ~clk;

    // Generator model: registered out, high for 10*m clk, period 10*(m+n) clk.
    int   g_cnt = 0;
    logic g_out = 1'b0;
    always @(posedge clk) begin
        if (gen_rst) begin
            g_cnt <= 0;
            g_out <= 1'b0;
        end else begin
            g_out <= (g_cnt < 10 * int'(m_out));
            g_cnt <= (g_cnt >= 10 * (int'(m_out) + int'(n_out)) - 1) ? 0 : g_cnt + 1;
        end
    end
    assign gen_out = g_out;

    int   n_checks = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic prev_out = 1'b0;
    logic rise_now = 1'b0;
    int   rises[$];
    int   falls[$];
    int   ndone = 0;
    int   done_cyc = -1;

    typedef struct {
        int addr;
        int m;
        int n;
        int rep;
        int exp_err;
    } wvec_t;
    wvec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        rise_now = gen_out && !prev_out;
        if (rise_now) rises.push_back(cyc);
        if (!gen_out && prev_out) falls.push_back(cyc);
        prev_out = gen_out;
        if (done) begin
            ndone++;
            done_cyc = cyc;
        end
    endtask

    function automatic int rise_at(input int i);
        return (rises.size() > i) ? rises[i] : -100000;
    endfunction

    function automatic int fall_at(input int i);
        return (falls.size() > i) ? falls[i] : -100000;
    endfunction

    task automatic clear_mon();
        rises.delete();
        falls.delete();
        ndone = 0;
        done_cyc = -1;
    endtask

    task automatic wr(input int a, input int m, input int n, input int r);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_m    = M'(m);
        wr_n    = N'(n);
        wr_rep  = REP_W'(r);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_start(input int l);
        len   = (AW+1)'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int k = 0;
        while (busy && k < limit) begin
            tick();
            k++;
        end
        check(name, int'(busy), 0);
    endtask

    task automatic wait_rise(input int limit, input string name);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!rise_now && k < limit);
        check(name, int'(rise_now), 1);
    endtask

    initial begin
        int c0;
        vecs[0] = '{addr: 0, m: 1, n: 1, rep: 2, exp_err: 0};
        vecs[1] = '{addr: 1, m: 2, n: 3, rep: 1, exp_err: 0};
        vecs[2] = '{addr: 2, m: 0, n: 5, rep: 1, exp_err: 1};
        vecs[3] = '{addr: 2, m: 5, n: 0, rep: 1, exp_err: 1};
        vecs[4] = '{addr: 3, m: 1, n: 2, rep: 0, exp_err: 0};
        vecs[5] = '{addr: 4, m: 2, n: 2, rep: 3, exp_err: 0};

        // Reset values
        repeat (3) tick();
        check("rst gen_rst", int'(gen_rst), 1);
        check("rst m_out", int'(m_out), 0);
        check("rst n_out", int'(n_out), 0);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst wr_err", int'(wr_err), 0);
        check("rst cur_idx", int'(cur_idx), 0);
        rst_n = 1'b1;
        tick();

        // Table writes, including rejected zero-field writes
        foreach (vecs[i]) begin
            wr(vecs[i].addr, vecs[i].m, vecs[i].n, vecs[i].rep);
            check($sformatf("wr%0d wr_err", i), int'(wr_err), vecs[i].exp_err);
            tick();
            check($sformatf("wr%0d wr_err clears", i), int'(wr_err), 0);
        end

        // Two-entry playback: 2x20-cycle periods then one 50-cycle period
        clear_mon();
        do_start(2);
        c0 = cyc;
        check("A busy", int'(busy), 1);
        check("A gen_rst", int'(gen_rst), 0);
        check("A m_out", int'(m_out), 1);
        check("A n_out", int'(n_out), 1);
        check("A cur_idx", int'(cur_idx), 0);
        wait_idle(400, "A returns idle");
        check("A done with busy low", int'(done), 1);
        check("A gen_rst after end", int'(gen_rst), 1);
        check("A rise count", rises.size(), 4);
        check("A first rise latency", rise_at(0) - c0, 1);
        check("A period 1", rise_at(1) - rise_at(0), 20);
        check("A period 2", rise_at(2) - rise_at(1), 20);
        check("A period 3", rise_at(3) - rise_at(2), 50);
        check("A high 1", fall_at(0) - rise_at(0), 10);
        check("A high 3", fall_at(2) - rise_at(2), 20);
        check("A done after final rise", done_cyc - rise_at(3), 1);
        tick();
        check("A done one cycle", int'(done), 0);
        check("A done count", ndone, 1);

        // Write while busy is rejected and leaves the table intact
        do_start(1);
        repeat (3) tick();
        wr(0, 9, 9, 1);
        check("B busy write wr_err", int'(wr_err), 1);
        tick();
        check("B wr_err clears", int'(wr_err), 0);
        wait_idle(200, "B returns idle");
        do_start(1);
        check("B entry0 m kept", int'(m_out), 1);
        check("B entry0 n kept", int'(n_out), 1);
        wait_idle(200, "B replay idle");

        // rep=0 plays exactly one period
        wr(0, 1, 2, 0);
        check("C write ok", int'(wr_err), 0);
        clear_mon();
        do_start(1);
        wait_idle(200, "C returns idle");
        check("C rise count", rises.size(), 2);
        check("C period", rise_at(1) - rise_at(0), 30);
        check("C done count", ndone, 1);

        // Stop 5 cycles into a 40-cycle period
        wr(0, 2, 2, 3);
        clear_mon();
        do_start(1);
        wait_rise(20, "D first rise");
        repeat (5) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("D busy after stop", int'(busy), 1);
        wait_idle(100, "D returns idle");
        check("D idle after next rise", cyc - rise_at(1), 1);
        check("D rise count", rises.size(), 2);
        check("D gen_rst", int'(gen_rst), 1);
        check("D no done", ndone, 0);

        // start with len=0 and stop in IDLE are ignored
        do_start(0);
        check("E len0 busy", int'(busy), 0);
        check("E len0 gen_rst", int'(gen_rst), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("E stop idle busy", int'(busy), 0);

        // Looping
        wr(0, 1, 1, 1);
        wr(1, 1, 1, 1);
        loop_en = 1'b1;
        clear_mon();
        do_start(2);
`ifdef SQW_SEQ_LOOP_EN
        wait_rise(20, "F first rise");
        for (int i = 0; i < 4; i++) begin
            wait_rise(40, $sformatf("F rise %0d", i + 1));
            tick();
            check($sformatf("F cur_idx %0d", i + 1), int'(cur_idx), (i % 2 == 0) ? 1 : 0);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(100, "F stop idle");
        check("F no done", ndone, 0);
`else
        wait_idle(200, "F returns idle");
        check("F rise count", rises.size(), 3);
        check("F done count", ndone, 1);
`endif
        loop_en = 1'b0;

        // Asynchronous reset mid-run
        wr(0, 2, 2, 1);
        do_start(2);
        repeat (30) tick();
        #3 rst_n = 1'b0;
        #1;
        check("G busy", int'(busy), 0);
        check("G gen_rst", int'(gen_rst), 1);
        check("G m_out", int'(m_out), 0);
        check("G n_out", int'(n_out), 0);
        check("G cur_idx", int'(cur_idx), 0);
        check("G done", int'(done), 0);
        tick();
        rst_n = 1'b1;
        tick();
        do_start(1);
        check("G table cleared m", int'(m_out), 0);
        check("G busy after start", int'(busy), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        wr(0, 1, 1, 1);
        clear_mon();
        do_start(1);
        check("G replay m_out", int'(m_out), 1);
        check("G replay cur_idx", int'(cur_idx), 0);
        wait_idle(200, "G replay idle");
        check("G replay done", ndone, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
